tlb: RTL and testbench
======================

// Module: tlb
// PURPOSE
//  Fully-associative MIPS32 joint TLB: responder for the CP0 tlbwi/tlbr/tlbp traffic issued from writeback, plus
//  registered translation lookup for fetch (port 0) and data access (port 1). Holds TLBNUM entries of
//  {VPN2,ASID,G,PFN0/C0/D0/V0,PFN1/C1/D1/V1}. Each search port returns a 1-cycle-latency registered result.
// PARAMETERS
//  TLBNUM   16   entry count, power of two
//  IDXW     4    index width, = log2(TLBNUM)
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high
//  sN_req        in   1   search request, N=0,1 (port 0 = fetch/tlbp, port 1 = data)
//  sN_vpn2       in   19  VA[31:13]
//  sN_odd_page   in   1   VA[12]; selects the odd or even half of the entry
//  sN_asid       in   8   current ASID
//  sN_rsp_valid  out  1   result valid, exactly 1 cycle after sN_req
//  sN_found      out  1   hit
//  sN_index      out  IDXW  index of the hitting entry
//  sN_pfn        out  20  PFN of the selected half
//  sN_c/sN_d/sN_v out 3/1/1 cache attribute, dirty, valid of the selected half
//  we            in   1   write entry w_index (tlbwi)
//  w_index       in   IDXW  write index
//  w_vpn2,w_asid,w_g  in 19,8,1  entry tag fields
//  w_pfn0,w_c0,w_d0,w_v0 in 20,3,1,1  even page
//  w_pfn1,w_c1,w_d1,w_v1 in 20,3,1,1  odd page
//  r_index       in   IDXW  read index (tlbr)
//  r_vpn2..r_v1  out  as w_*  combinational contents of entry r_index
// BEHAVIOUR
//  - Reset: all entry fields cleared (G=0, V0=V1=0, D=0, PFN=0); sN_rsp_valid=0; sN_found=0; sN_index/pfn/c/d/v=0.
//  - Match(i) = (entry[i].vpn2 == sN_vpn2) && (entry[i].g || entry[i].asid == sN_asid). V bits are NOT part of
//    the match: a hit with V=0 returns found=1, v=0, so the requester raises TLB-invalid instead of TLB-refill.
//  - Multiple hits (software error): the lowest index wins and the result is deterministic.
//  - Latency: the compare is combinational in cycle T on the array state at the start of T. Results are
//    registered at the end of T. sN_rsp_valid=1 in T+1 only. The result holds until the next sN_req.
//    sN_req is accepted every cycle, with no back-pressure.
//  - Write: if we=1 at edge T, entry[w_index] updates at that edge. W_g is stored as given; the writer ANDs G0&G1.
//  - Write/search same cycle: the search uses pre-write contents, and the new entry is visible to requests in T+1.
//  - Read port: r_* is combinational from the array. With r_index == w_index and we=1, it shows old contents
//    until the edge.
//  - No Index.P or fault logic in the TLB. found=0 lets the requester/CP0 set P or raise a refill.
//  - reset asserted mid-lookup: the pending result is discarded and sN_rsp_valid=0 in the next cycle.
//  - Odd-page select: sN_odd_page=1 returns the *1 fields, else the *0 fields, of the hit entry; with a miss,
//    PFN/C/D/V are 0.
// STRUCTURE
//  - Shared package/header: TLBNUM, IDXW, field widths (VPN2_W=19, ASID_W=8, PFN_W=20, C_W=3), the tlb_entry
//    struct/bus layout, and the s/w/r bus bit positions used by the fetch, execute and writeback stages.
//  - Sub-module tlb_search_port (instantiated twice):
//      * per-entry match vector
//      * priority encoder (lowest index)
//      * odd/even mux
//      * output register stage with rsp_valid
//  - The entry array and write/read logic stay in tlb.
// TESTING
//  - Reset then s0_req vpn2=0x00001, asid=0 -> T+1: rsp_valid=1, found=0, pfn=0, v=0.
//  - Write idx3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0xAAAAA v0=1, pfn1=0xBBBBB v1=1 d1=1 c1=3}.
//      * s1 vpn2=0x12345 odd=1 asid=5 -> found=1, idx=3, pfn=0xBBBBB, c=3, d=1, v=1.
//      * same request with asid=6 -> found=0.
//  - Write idx7 with g=1, vpn2=0x00400, v0=0.
//      * s0 odd=0, any asid -> found=1, idx=7, v=0.
//      * r_index=7 -> r_g=1, r_vpn2=0x00400.
//  - Write idx2 and idx9 with the same vpn2/asid -> search returns idx=2.
//      * rewrite idx2 with a different vpn2 -> search returns idx=9.
//  - we=1 to idx5 (new vpn2=0x7FFFF) in the same cycle as s0_req for 0x7FFFF -> found=0.
//      * repeat the request next cycle -> found=1, idx=5.
//  - Back-to-back s0_req for 3 cycles with alternating vpn2 -> 3 consecutive rsp_valid cycles with the matching
//    results. Assert reset in the middle -> rsp_valid=0 the next cycle, and all prior entries miss.

Source files
------------

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: sizes, field widths, entry layout and the tag-match rule
// used by every stage that talks to the joint TLB.
package tlb_pkg;
   localparam int TLBNUM = 16;
   localparam int IDXW   = 4;
   localparam int VPN2_W = 19;
   localparam int ASID_W = 8;
   localparam int PFN_W  = 20;
   localparam int C_W    = 3;

   typedef struct packed {
      logic [VPN2_W-1:0] vpn2;
      logic [ASID_W-1:0] asid;
      logic              g;
      logic [PFN_W-1:0]  pfn0;
      logic [C_W-1:0]    c0;
      logic              d0;
      logic              v0;
      logic [PFN_W-1:0]  pfn1;
      logic [C_W-1:0]    c1;
      logic              d1;
      logic              v1;
   } tlb_entry_t;

   typedef struct packed {
      logic              found;
      logic [IDXW-1:0]   index;
      logic [PFN_W-1:0]  pfn;
      logic [C_W-1:0]    c;
      logic              d;
      logic              v;
   } tlb_result_t;

   // V bits are deliberately ignored so an invalid hit can be told apart from a refill.
   function automatic logic entry_match(input tlb_entry_t e, input logic [VPN2_W-1:0] vpn2,
                                        input logic [ASID_W-1:0] asid);
      return (e.vpn2 == vpn2) && (e.g || (e.asid == asid));
   endfunction
endpackage

// File: rtl/tlb_if.sv
// TLB bus: two search ports, the tlbwi write port and the tlbr read port.
// Search: sN_req is taken every cycle with no back-pressure; sN_rsp_valid pulses one cycle later.
interface tlb_if;
   import tlb_pkg::*;

   logic              s0_req,       s1_req;
   logic [VPN2_W-1:0] s0_vpn2,      s1_vpn2;
   logic              s0_odd_page,  s1_odd_page;
   logic [ASID_W-1:0] s0_asid,      s1_asid;
   logic              s0_rsp_valid, s1_rsp_valid;
   logic              s0_found,     s1_found;
   logic [IDXW-1:0]   s0_index,     s1_index;
   logic [PFN_W-1:0]  s0_pfn,       s1_pfn;
   logic [C_W-1:0]    s0_c,         s1_c;
   logic              s0_d,         s1_d;
   logic              s0_v,         s1_v;

   logic              we;
   logic [IDXW-1:0]   w_index;
   logic [VPN2_W-1:0] w_vpn2;
   logic [ASID_W-1:0] w_asid;
   logic              w_g;
   logic [PFN_W-1:0]  w_pfn0, w_pfn1;
   logic [C_W-1:0]    w_c0, w_c1;
   logic              w_d0, w_d1, w_v0, w_v1;

   logic [IDXW-1:0]   r_index;
   logic [VPN2_W-1:0] r_vpn2;
   logic [ASID_W-1:0] r_asid;
   logic              r_g;
   logic [PFN_W-1:0]  r_pfn0, r_pfn1;
   logic [C_W-1:0]    r_c0, r_c1;
   logic              r_d0, r_d1, r_v0, r_v1;

   modport master (
      output s0_req, s0_vpn2, s0_odd_page, s0_asid,
      output s1_req, s1_vpn2, s1_odd_page, s1_asid,
      input  s0_rsp_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      input  s1_rsp_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      output r_index,
      input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
   );

   modport slave (
      input  s0_req, s0_vpn2, s0_odd_page, s0_asid,
      input  s1_req, s1_vpn2, s1_odd_page, s1_asid,
      output s0_rsp_valid, s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
      output s1_rsp_valid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
      input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
      input  r_index,
      output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
   );
endinterface

// File: rtl/tlb_search_port.sv
// One TLB lookup port: parallel tag compare, lowest-index priority pick, even/odd
// page select, and a result register that holds until the next request.
module tlb_search_port
   import tlb_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  tlb_entry_t [TLBNUM-1:0]       entries,
   input  logic                          req,
   input  logic [VPN2_W-1:0]             vpn2,
   input  logic                          odd_page,
   input  logic [ASID_W-1:0]             asid,
   output logic                          rsp_valid,
   output logic                          found,
   output logic [IDXW-1:0]               index,
   output logic [PFN_W-1:0]              pfn,
   output logic [C_W-1:0]                c,
   output logic                          d,
   output logic                          v
);
   logic [TLBNUM-1:0] match;
   tlb_entry_t        sel;
   tlb_result_t       hit, res_d, res_q;
   logic              rsp_valid_d, rsp_valid_q;

   always_comb begin
      match = '0;
      for (int i = 0; i < TLBNUM; i++) match[i] = entry_match(entries[i], vpn2, asid);
   end

   // Scanning downward lets the lowest matching index overwrite any higher one.
   always_comb begin
      hit = '0;
      sel = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (match[i]) begin
            hit.found = 1'b1;
            hit.index = i[IDXW-1:0];
            sel       = entries[i];
         end
      end
      if (hit.found) begin
         hit.pfn = odd_page ? sel.pfn1 : sel.pfn0;
         hit.c   = odd_page ? sel.c1   : sel.c0;
         hit.d   = odd_page ? sel.d1   : sel.d0;
         hit.v   = odd_page ? sel.v1   : sel.v0;
      end
   end

   always_comb begin
      res_d       = req ? hit : res_q;
      rsp_valid_d = req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         res_q       <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         res_q       <= res_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign found     = res_q.found;
   assign index     = res_q.index;
   assign pfn       = res_q.pfn;
   assign c         = res_q.c;
   assign d         = res_q.d;
   assign v         = res_q.v;
endmodule

// File: rtl/tlb.sv
// MIPS32 joint TLB: entry array with tlbwi write and combinational tlbr read,
// shared by a fetch search port (0) and a data search port (1).
module tlb
   import tlb_pkg::*;
(
   input logic clk,
   input logic reset,
   tlb_if.slave bus
);
   tlb_entry_t [TLBNUM-1:0] entry_q, entry_d;
   tlb_entry_t              w_entry, r_entry;

   assign w_entry = '{vpn2: bus.w_vpn2, asid: bus.w_asid, g: bus.w_g,
                      pfn0: bus.w_pfn0, c0: bus.w_c0, d0: bus.w_d0, v0: bus.w_v0,
                      pfn1: bus.w_pfn1, c1: bus.w_c1, d1: bus.w_d1, v1: bus.w_v1};

   always_comb begin
      entry_d = entry_q;
      if (bus.we) entry_d[bus.w_index] = w_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) entry_q <= '0;
      else       entry_q <= entry_d;
   end

   // Searches and reads see entry_q, so a same-cycle write only shows up after the edge.
   assign r_entry    = entry_q[bus.r_index];
   assign bus.r_vpn2 = r_entry.vpn2;
   assign bus.r_asid = r_entry.asid;
   assign bus.r_g    = r_entry.g;
   assign bus.r_pfn0 = r_entry.pfn0;
   assign bus.r_c0   = r_entry.c0;
   assign bus.r_d0   = r_entry.d0;
   assign bus.r_v0   = r_entry.v0;
   assign bus.r_pfn1 = r_entry.pfn1;
   assign bus.r_c1   = r_entry.c1;
   assign bus.r_d1   = r_entry.d1;
   assign bus.r_v1   = r_entry.v1;

   tlb_search_port u_s0 (
      .clk(clk), .reset(reset), .entries(entry_q),
      .req(bus.s0_req), .vpn2(bus.s0_vpn2), .odd_page(bus.s0_odd_page), .asid(bus.s0_asid),
      .rsp_valid(bus.s0_rsp_valid), .found(bus.s0_found), .index(bus.s0_index),
      .pfn(bus.s0_pfn), .c(bus.s0_c), .d(bus.s0_d), .v(bus.s0_v)
   );

   tlb_search_port u_s1 (
      .clk(clk), .reset(reset), .entries(entry_q),
      .req(bus.s1_req), .vpn2(bus.s1_vpn2), .odd_page(bus.s1_odd_page), .asid(bus.s1_asid),
      .rsp_valid(bus.s1_rsp_valid), .found(bus.s1_found), .index(bus.s1_index),
      .pfn(bus.s1_pfn), .c(bus.s1_c), .d(bus.s1_d), .v(bus.s1_v)
   );
endmodule

// File: tb/tb_tlb.sv
// Self-checking bench for tlb: directed vector table, multi-cycle corner sequences,
// and randomized traffic against an array-based reference model.
module tb_tlb;
   import tlb_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tlb_if bus();
   tlb dut (.clk(clk), .reset(reset), .bus(bus));

   int checks   = 0;
   int failures = 0;
   tlb_entry_t model[TLBNUM];

   typedef struct {
      int                port;
      logic [VPN2_W-1:0] vpn2;
      logic              odd;
      logic [ASID_W-1:0] asid;
      tlb_result_t       exp;
      string             name;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic tlb_entry_t mk(input logic [VPN2_W-1:0] vpn2, input logic [ASID_W-1:0] asid,
                                     input logic g, input logic [PFN_W-1:0] pfn0, input logic [C_W-1:0] c0,
                                     input logic d0, input logic v0, input logic [PFN_W-1:0] pfn1,
                                     input logic [C_W-1:0] c1, input logic d1, input logic v1);
      return '{vpn2: vpn2, asid: asid, g: g, pfn0: pfn0, c0: c0, d0: d0, v0: v0,
               pfn1: pfn1, c1: c1, d1: d1, v1: v1};
   endfunction

   function automatic tlb_result_t res(input logic found, input int idx, input logic [PFN_W-1:0] pfn,
                                       input logic [C_W-1:0] c, input logic d, input logic v);
      return '{found: found, index: IDXW'(idx), pfn: pfn, c: c, d: d, v: v};
   endfunction

   // Reference: collect every matching index in ascending order and report the first.
   function automatic tlb_result_t model_lookup(input logic [VPN2_W-1:0] vpn2, input logic odd,
                                                input logic [ASID_W-1:0] asid);
      int hits[$];
      tlb_entry_t e;
      for (int i = 0; i < TLBNUM; i++)
         if (model[i].vpn2 == vpn2 && (model[i].g || model[i].asid == asid)) hits.push_back(i);
      if (hits.size() == 0) return '0;
      e = model[hits[0]];
      if (odd) return res(1'b1, hits[0], e.pfn1, e.c1, e.d1, e.v1);
      return res(1'b1, hits[0], e.pfn0, e.c0, e.d0, e.v0);
   endfunction

   task automatic clear_reqs();
      bus.s0_req = 1'b0; bus.s0_vpn2 = '0; bus.s0_odd_page = 1'b0; bus.s0_asid = '0;
      bus.s1_req = 1'b0; bus.s1_vpn2 = '0; bus.s1_odd_page = 1'b0; bus.s1_asid = '0;
   endtask

   task automatic drive_search(input int port, input logic [VPN2_W-1:0] vpn2, input logic odd,
                               input logic [ASID_W-1:0] asid);
      if (port == 0) begin
         bus.s0_req = 1'b1; bus.s0_vpn2 = vpn2; bus.s0_odd_page = odd; bus.s0_asid = asid;
      end else begin
         bus.s1_req = 1'b1; bus.s1_vpn2 = vpn2; bus.s1_odd_page = odd; bus.s1_asid = asid;
      end
   endtask

   task automatic drive_write(input int idx, input tlb_entry_t e);
      bus.we = 1'b1; bus.w_index = IDXW'(idx);
      bus.w_vpn2 = e.vpn2; bus.w_asid = e.asid; bus.w_g = e.g;
      bus.w_pfn0 = e.pfn0; bus.w_c0 = e.c0; bus.w_d0 = e.d0; bus.w_v0 = e.v0;
      bus.w_pfn1 = e.pfn1; bus.w_c1 = e.c1; bus.w_d1 = e.d1; bus.w_v1 = e.v1;
   endtask

   task automatic write_entry(input int idx, input tlb_entry_t e);
      drive_write(idx, e);
      step();
      bus.we = 1'b0;
      model[idx] = e;
   endtask

   task automatic check_port(input int port, input tlb_result_t exp, input logic exp_valid,
                             input string tag);
      tlb_result_t act;
      logic        vld;
      if (port == 0) begin
         vld = bus.s0_rsp_valid;
         act = '{found: bus.s0_found, index: bus.s0_index, pfn: bus.s0_pfn, c: bus.s0_c, d: bus.s0_d, v: bus.s0_v};
      end else begin
         vld = bus.s1_rsp_valid;
         act = '{found: bus.s1_found, index: bus.s1_index, pfn: bus.s1_pfn, c: bus.s1_c, d: bus.s1_d, v: bus.s1_v};
      end
      chk({tag, ".rsp_valid"}, 32'(vld), 32'(exp_valid));
      chk({tag, ".found"}, 32'(act.found), 32'(exp.found));
      if (exp.found) chk({tag, ".index"}, 32'(act.index), 32'(exp.index));
      chk({tag, ".pfn"}, 32'(act.pfn), 32'(exp.pfn));
      chk({tag, ".c"}, 32'(act.c), 32'(exp.c));
      chk({tag, ".d"}, 32'(act.d), 32'(exp.d));
      chk({tag, ".v"}, 32'(act.v), 32'(exp.v));
   endtask

   function automatic logic [VPN2_W-1:0] pick_vpn2();
      case ($urandom_range(0, 4))
         0:       return 19'h12345;
         1:       return 19'h00400;
         2:       return 19'h0ABCD;
         3:       return 19'h7FFFF;
         default: return VPN2_W'($urandom_range(0, 19'h7FFFF));
      endcase
   endfunction

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      tlb_result_t held[2];
      tlb_result_t exp0, exp1, exp2;
      tlb_entry_t  e;
      logic        rq[2];

      reset = 1'b1;
      clear_reqs();
      bus.we = 1'b0;
      drive_write(0, '0);
      bus.we = 1'b0;
      bus.r_index = '0;
      for (int i = 0; i < TLBNUM; i++) model[i] = '0;
      step(); step();
      reset = 1'b0;

      check_port(0, '0, 1'b0, "reset_s0");
      check_port(1, '0, 1'b0, "reset_s1");
      chk("reset_r_v0", 32'(bus.r_v0), 32'd0);
      chk("reset_r_g", 32'(bus.r_g), 32'd0);

      drive_search(0, 19'h00001, 1'b0, 8'h00);
      step();
      clear_reqs();
      check_port(0, '0, 1'b1, "first_miss");
      step();
      check_port(0, '0, 1'b0, "first_idle");

      write_entry(3, mk(19'h12345, 8'h05, 1'b0, 20'hAAAAA, 3'd0, 1'b0, 1'b1, 20'hBBBBB, 3'd3, 1'b1, 1'b1));
      write_entry(7, mk(19'h00400, 8'h22, 1'b1, 20'h00111, 3'd2, 1'b1, 1'b0, 20'h00222, 3'd5, 1'b0, 1'b1));

      vecs[0] = '{1, 19'h12345, 1'b1, 8'h05, res(1, 3, 20'hBBBBB, 3'd3, 1, 1), "odd_hit"};
      vecs[1] = '{1, 19'h12345, 1'b1, 8'h06, res(0, 0, 20'h0, 3'd0, 0, 0), "asid_miss"};
      vecs[2] = '{0, 19'h12345, 1'b0, 8'h05, res(1, 3, 20'hAAAAA, 3'd0, 0, 1), "even_hit"};
      vecs[3] = '{0, 19'h00400, 1'b0, 8'h33, res(1, 7, 20'h00111, 3'd2, 1, 0), "global_invalid"};
      vecs[4] = '{1, 19'h00400, 1'b1, 8'hFF, res(1, 7, 20'h00222, 3'd5, 0, 1), "global_odd"};
      vecs[5] = '{0, 19'h12346, 1'b0, 8'h05, res(0, 0, 20'h0, 3'd0, 0, 0), "vpn_miss"};
      for (int i = 0; i < 6; i++) begin
         drive_search(vecs[i].port, vecs[i].vpn2, vecs[i].odd, vecs[i].asid);
         step();
         clear_reqs();
         check_port(vecs[i].port, vecs[i].exp, 1'b1, vecs[i].name);
      end

      bus.r_index = 4'd7;
      #1;
      chk("read_r_g", 32'(bus.r_g), 32'd1);
      chk("read_r_vpn2", 32'(bus.r_vpn2), 32'h00400);

      // Two entries sharing a tag: the lower index must win until it is retagged.
      write_entry(2, mk(19'h0ABCD, 8'h11, 1'b0, 20'h22222, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
      write_entry(9, mk(19'h0ABCD, 8'h11, 1'b0, 20'h99999, 3'd4, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
      drive_search(1, 19'h0ABCD, 1'b0, 8'h11);
      step();
      clear_reqs();
      check_port(1, res(1, 2, 20'h22222, 3'd1, 0, 1), 1'b1, "multi_hit_low");
      write_entry(2, mk(19'h0ABCE, 8'h11, 1'b0, 20'h22222, 3'd1, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
      drive_search(1, 19'h0ABCD, 1'b0, 8'h11);
      step();
      clear_reqs();
      check_port(1, res(1, 9, 20'h99999, 3'd4, 1, 1), 1'b1, "multi_hit_retag");

      // Write and search in the same cycle: search and read port see the old entry.
      e = mk(19'h7FFFF, 8'h00, 1'b0, 20'h55555, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
      drive_write(5, e);
      drive_search(0, 19'h7FFFF, 1'b0, 8'h00);
      bus.r_index = 4'd5;
      #1;
      chk("wr_same_r_vpn2_old", 32'(bus.r_vpn2), 32'd0);
      @(posedge clk);
      #1;
      bus.we = 1'b0;
      model[5] = e;
      clear_reqs();
      check_port(0, '0, 1'b1, "wr_same_search_old");
      chk("wr_same_r_vpn2_new", 32'(bus.r_vpn2), 32'h7FFFF);
      drive_search(0, 19'h7FFFF, 1'b0, 8'h00);
      step();
      clear_reqs();
      check_port(0, res(1, 5, 20'h55555, 3'd0, 0, 1), 1'b1, "wr_next_cycle");

      held[0] = res(1, 5, 20'h55555, 3'd0, 0, 1);
      held[1] = res(1, 9, 20'h99999, 3'd4, 1, 1);
      for (int n = 0; n < 300; n++) begin
         for (int p = 0; p < 2; p++) begin
            rq[p] = ($urandom_range(0, 3) != 0);
            if (rq[p]) begin
               logic [VPN2_W-1:0] vv;
               logic              od;
               logic [ASID_W-1:0] as;
               vv = pick_vpn2();
               od = 1'($urandom_range(0, 1));
               as = ASID_W'($urandom_range(0, 3));
               drive_search(p, vv, od, as);
               held[p] = model_lookup(vv, od, as);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            e = mk(pick_vpn2(), ASID_W'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0),
                   PFN_W'($urandom), C_W'($urandom), 1'($urandom), 1'($urandom),
                   PFN_W'($urandom), C_W'($urandom), 1'($urandom), 1'($urandom));
            drive_write(int'($urandom_range(0, TLBNUM - 1)), e);
            model[bus.w_index] = e;
         end
         step();
         bus.we = 1'b0;
         clear_reqs();
         check_port(0, held[0], rq[0], "rand_s0");
         check_port(1, held[1], rq[1], "rand_s1");
      end

      // Three back-to-back lookups on port 0, then reset lands on a fourth.
      exp0 = model_lookup(19'h12345, 1'b1, 8'h05);
      exp1 = model_lookup(19'h00400, 1'b0, 8'h22);
      exp2 = model_lookup(19'h12345, 1'b0, 8'h05);
      drive_search(0, 19'h12345, 1'b1, 8'h05);
      step();
      drive_search(0, 19'h00400, 1'b0, 8'h22);
      check_port(0, exp0, 1'b1, "b2b_0");
      step();
      drive_search(0, 19'h12345, 1'b0, 8'h05);
      check_port(0, exp1, 1'b1, "b2b_1");
      step();
      drive_search(0, 19'h0ABCD, 1'b0, 8'h11);
      reset = 1'b1;
      check_port(0, exp2, 1'b1, "b2b_2");
      step();
      reset = 1'b0;
      clear_reqs();
      for (int i = 0; i < TLBNUM; i++) model[i] = '0;
      check_port(0, '0, 1'b0, "reset_mid");
      drive_search(0, 19'h12345, 1'b1, 8'h05);
      drive_search(1, 19'h00400, 1'b0, 8'h22);
      step();
      clear_reqs();
      check_port(0, model_lookup(19'h12345, 1'b1, 8'h05), 1'b1, "post_reset_s0");
      check_port(1, model_lookup(19'h00400, 1'b0, 8'h22), 1'b1, "post_reset_s1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
